// File: rtl/als_filter.sv
// Ambient-light moving-average filter: DEPTH-sample ring buffer, running sum,
// fill tracking and a hysteresis dark indicator, all updated one cycle after a sample.
module als_filter #(
  parameter int unsigned LOG2_DEPTH = 3,
  parameter logic [7:0]  DARK_ON    = 8'd40,
  parameter logic [7:0]  DARK_OFF   = 8'd60
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       clear,
  output logic       out_valid,
  output logic [7:0] out_avg,
  output logic       out_primed,
  output logic       out_dark
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned PTR_W = LOG2_DEPTH;
  localparam int unsigned SUM_W = 8 + LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_RUN} state_t;

  state_t           state;
  logic [7:0]       ring [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] fill_cnt;

  logic             accept;
  logic [SUM_W-1:0] new_sum;
  logic [7:0]       new_avg;
  logic             last_fill;
  logic             new_primed;

  // Evicted sample is removed before the new one is added, so the sum never exceeds DEPTH*255.
  always_comb begin
    accept     = in_valid && !clear;
    new_sum    = sum - SUM_W'(ring[wr_ptr]) + SUM_W'(in_data);
    new_avg    = new_sum[SUM_W-1:LOG2_DEPTH];
    last_fill  = (state == ST_FILL) && (fill_cnt == CNT_W'(DEPTH - 1));
    new_primed = out_primed || last_fill;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      for (int unsigned i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr     <= '0;
      sum        <= '0;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      out_avg    <= '0;
      out_primed <= 1'b0;
      out_dark   <= 1'b0;
    end else if (clear) begin
      state      <= ST_EMPTY;
      for (int unsigned i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr     <= '0;
      sum        <= '0;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      out_avg    <= '0;
      out_primed <= 1'b0;
      out_dark   <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        ring[wr_ptr] <= in_data;
        wr_ptr       <= wr_ptr + PTR_W'(1);
        sum          <= new_sum;
        out_avg      <= new_avg;
        out_primed   <= new_primed;
        // Dark flag only moves once the window is full, with hysteresis between thresholds.
        if (new_primed) begin
          if (!out_dark && (new_avg < DARK_ON)) begin
            out_dark <= 1'b1;
          end else if (out_dark && (new_avg > DARK_OFF)) begin
            out_dark <= 1'b0;
          end
        end
        case (state)
          ST_EMPTY: begin
            state    <= ST_FILL;
            fill_cnt <= CNT_W'(1);
          end
          ST_FILL: begin
            fill_cnt <= fill_cnt + CNT_W'(1);
            if (last_fill) state <= ST_RUN;
          end
          ST_RUN:   state <= ST_RUN;
          default:  state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_als_filter.sv
// Self-checking bench for als_filter: directed vector table, corner sequences,
// and randomized traffic against a sliding-window reference model.
module tb_als_filter;

  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 1 << LOG2_DEPTH;
  localparam int DARK_ON    = 40;
  localparam int DARK_OFF   = 60;
  localparam int NVEC       = 24;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clear;
  logic       out_valid;
  logic [7:0] out_avg;
  logic       out_primed;
  logic       out_dark;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] avg;
    logic       primed;
    logic       dark;
  } vec_t;

  vec_t tbl [NVEC];

  // Reference model state: expected registered outputs and recent sample history.
  int         hist [$];
  logic       m_valid, m_primed, m_dark;
  logic [7:0] m_avg;

  als_filter #(
    .LOG2_DEPTH(LOG2_DEPTH),
    .DARK_ON   (8'(DARK_ON)),
    .DARK_OFF  (8'(DARK_OFF))
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_avg   (out_avg),
    .out_primed(out_primed),
    .out_dark  (out_dark)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_valid  = 1'b0;
    m_avg    = '0;
    m_primed = 1'b0;
    m_dark   = 1'b0;
  endtask

  // Average of the last DEPTH samples since reset/clear, missing ones counted as zero.
  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    int s;
    if (c) begin
      model_reset();
    end else if (v) begin
      hist.push_back(int'(d));
      if (hist.size() > DEPTH) void'(hist.pop_front());
      s = 0;
      foreach (hist[k]) s += hist[k];
      m_avg   = 8'(s / DEPTH);
      m_valid = 1'b1;
      if (hist.size() == DEPTH) m_primed = 1'b1;
      if (m_primed) begin
        if (!m_dark && int'(m_avg) < DARK_ON) m_dark = 1'b1;
        else if (m_dark && int'(m_avg) > DARK_OFF) m_dark = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare DUT against the model.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge sysclk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    model_step(v, d, c);
    check("out_valid",  32'(out_valid),  32'(m_valid));
    check("out_avg",    32'(out_avg),    32'(m_avg));
    check("out_primed", 32'(out_primed), 32'(m_primed));
    check("out_dark",   32'(out_dark),   32'(m_dark));
  endtask

  initial begin
    int exp_avg [NVEC] = '{12, 25, 37, 50, 62, 75, 87, 100,
                           90, 80, 70, 60, 50, 40, 30, 20,
                           26, 32, 38, 45, 51, 57, 63, 70};
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].data   = (i < 8) ? 8'd100 : (i < 16) ? 8'd20 : 8'd70;
      tbl[i].avg    = 8'(exp_avg[i]);
      tbl[i].primed = (i >= 7);
      tbl[i].dark   = (i >= 14) && (i <= 21);
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_valid",  32'(out_valid),  32'd0);
    check("rst_avg",    32'(out_avg),    32'd0);
    check("rst_primed", 32'(out_primed), 32'd0);
    check("rst_dark",   32'(out_dark),   32'd0);
    rst = 1'b0;

    // Fill, dark assert across the wrap, hysteresis release; one sample every 3 cycles.
    for (int i = 0; i < NVEC; i++) begin
      step(1'b1, tbl[i].data, 1'b0);
      check($sformatf("vec%0d_avg", i),    32'(out_avg),    32'(tbl[i].avg));
      check($sformatf("vec%0d_primed", i), 32'(out_primed), 32'(tbl[i].primed));
      check($sformatf("vec%0d_dark", i),   32'(out_dark),   32'(tbl[i].dark));
      step(1'b0, 8'd0, 1'b0);
      step(1'b0, 8'd0, 1'b0);
    end

    // Asynchronous reset mid-stream, while out_valid is high.
    step(1'b1, 8'd55, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_valid",  32'(out_valid),  32'd0);
    check("arst_avg",    32'(out_avg),    32'd0);
    check("arst_primed", 32'(out_primed), 32'd0);
    check("arst_dark",   32'(out_dark),   32'd0);
    @(posedge sysclk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'd100, 1'b0);
    check("post_rst_avg", 32'(out_avg), 32'd12);

    // Back-to-back throughput after a flush.
    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    check("thru_avg",    32'(out_avg),    32'd11);
    check("thru_primed", 32'(out_primed), 32'd1);
    step(1'b0, 8'd0, 1'b0);
    check("thru_idle_valid", 32'(out_valid), 32'd0);

    // Clear colliding with a sample: sample dropped, everything zeroed.
    step(1'b1, 8'd200, 1'b1);
    check("clr_valid",  32'(out_valid),  32'd0);
    check("clr_avg",    32'(out_avg),    32'd0);
    check("clr_primed", 32'(out_primed), 32'd0);
    step(1'b1, 8'd80, 1'b0);
    check("clr_next_avg",    32'(out_avg),    32'd10);
    check("clr_next_primed", 32'(out_primed), 32'd0);

    // Randomized traffic, biased toward low light so the dark flag toggles.
    for (int n = 0; n < 1500; n++) begin
      logic       v, c;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      d = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 90)) : 8'($urandom_range(0, 255));
      step(v, d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
